// File: rtl/pattern_src_mc.sv
// Round-robin multi-channel test-pattern source on a valid/ready stream.
// Every beat carries the current pattern value of its channel; all outputs are registered.
//
// state | meaning
// IDLE  | waiting for start; out_valid low
// RUN   | presenting beats; busy high until last accept or abort
module pattern_src_mc #(
    parameter int                DATA_W    = 4,
    parameter int                NUM_CHAN  = 4,
    parameter logic [DATA_W-1:0] SEED      = '0,
    parameter logic [DATA_W-1:0] LFSR_POLY = DATA_W'(4'b1100),
    localparam int               CHAN_W    = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic [15:0]       burst_len,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CHAN_W-1:0] out_chan,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [15:0]       len_q, len_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0] pat_q [NUM_CHAN];
    logic [DATA_W-1:0] pat_d [NUM_CHAN];
    logic              valid_d, last_d, busy_d, done_d;
    logic [DATA_W-1:0] data_d;
    logic [CHAN_W-1:0] chan_d;
    logic [CHAN_W-1:0] nxt_chan;
    logic              accept;

    function automatic logic [DATA_W-1:0] pat_init(input logic [1:0] m, input int c);
        logic [DATA_W-1:0] v;
        v = SEED;
        case (m)
            2'd0: v = SEED;
            2'd1: v = SEED + DATA_W'(c);
            2'd2: v = DATA_W'(1) << (c % DATA_W);
            default: begin
                v = SEED ^ DATA_W'(c);
                if (v == '0) v = DATA_W'(1);
            end
        endcase
        return v;
    endfunction

    function automatic logic [DATA_W-1:0] pat_step(input logic [1:0] m, input logic [DATA_W-1:0] s);
        logic [DATA_W-1:0] v;
        v = s;
        case (m)
            2'd0: v = s;
            2'd1: v = s + DATA_W'(1);
            2'd2: v = {s[DATA_W-2:0], s[DATA_W-1]};
            default: v = (s >> 1) ^ (s[0] ? LFSR_POLY : '0);
        endcase
        return v;
    endfunction

    assign accept   = out_valid & out_ready;
    // out_chan doubles as the round-robin pointer while a burst is running
    assign nxt_chan = (out_chan == CHAN_W'(NUM_CHAN - 1)) ? '0 : out_chan + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && burst_len != 16'd0) state_d = RUN;
            RUN:     if (abort || (accept && out_last)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mode_d  = mode_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        pat_d   = pat_q;
        valid_d = out_valid;
        data_d  = out_data;
        chan_d  = out_chan;
        last_d  = out_last;
        busy_d  = busy;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (burst_len != 16'd0) begin
                        mode_d = mode;
                        len_d  = burst_len;
                        cnt_d  = '0;
                        for (int c = 0; c < NUM_CHAN; c++) pat_d[c] = pat_init(mode, c);
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                        data_d  = pat_init(mode, 0);
                        chan_d  = '0;
                        last_d  = (burst_len == 16'd1);
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    pat_d[out_chan] = pat_step(mode_q, pat_q[out_chan]);
                    cnt_d = cnt_q + 16'd1;
                end
                // abort wins over a simultaneous final accept, so no done pulse then
                if (abort) begin
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    last_d  = 1'b0;
                end else if (accept) begin
                    if (out_last) begin
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        chan_d = nxt_chan;
                        data_d = pat_d[nxt_chan];
                        last_d = (({1'b0, cnt_q} + 17'd2) == {1'b0, len_q});
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            for (int c = 0; c < NUM_CHAN; c++) pat_q[c] <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            pat_q     <= pat_d;
            out_valid <= valid_d;
            out_data  <= data_d;
            out_chan  <= chan_d;
            out_last  <= last_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_pattern_src_mc.sv
// Bench for pattern_src_mc: three instances (4, 1 and 2 channels) share one stimulus stream
// and are checked every cycle against a beat-index model of the burst.
module tb_pattern_src_mc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        out_ready = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic [15:0] burst_len = 16'd0;

    logic       v4, v1, v2, l4, l1, l2, b4, b1, b2, d4, d1, d2;
    logic [3:0] dat4, dat1, dat2;
    logic [1:0] ch4;
    logic       ch1, ch2;

    always #5 clk = ~clk;

    pattern_src_mc #(.DATA_W(4), .NUM_CHAN(4), .SEED(4'h0)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
        .burst_len(burst_len), .out_valid(v4), .out_ready(out_ready), .out_data(dat4),
        .out_chan(ch4), .out_last(l4), .busy(b4), .done(d4));

    pattern_src_mc #(.DATA_W(4), .NUM_CHAN(1), .SEED(4'h1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
        .burst_len(burst_len), .out_valid(v1), .out_ready(out_ready), .out_data(dat1),
        .out_chan(ch1), .out_last(l1), .busy(b1), .done(d1));

    pattern_src_mc #(.DATA_W(4), .NUM_CHAN(2), .SEED(4'h9)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
        .burst_len(burst_len), .out_valid(v2), .out_ready(out_ready), .out_data(dat2),
        .out_chan(ch2), .out_last(l2), .busy(b2), .done(d2));

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    // burst-level model: running flag, index of the beat on offer, latched mode/length
    bit m_run = 1'b0;
    bit m_done = 1'b0;
    int m_mode = 0;
    int m_len = 0;
    int m_k = 0;

    logic [3:0] q4[$], q1[$], q2[$];
    int exp_inc[$]  = '{0, 1, 2, 3, 1, 2};
    int exp_lfsr[$] = '{1, 12, 6, 3, 13, 10, 5, 14, 7, 15, 11, 9, 8, 4, 2, 1};
    int exp_walk[$] = '{1, 2, 2, 4, 4, 8, 8, 1};

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // value of beat k: channel k%n has been advanced k/n times from its initial value
    function automatic int exp_pat(input int n, input int seed, input int m, input int k);
        int c, j, s;
        c = k % n;
        j = k / n;
        case (m)
            0: s = seed;
            1: s = (seed + c + j) % 16;
            2: s = 1 << ((c + j) % 4);
            default: begin
                s = (seed ^ c) % 16;
                if (s == 0) s = 1;
                for (int i = 0; i < j; i++)
                    s = (s / 2) ^ (((s % 2) == 1) ? 12 : 0);
            end
        endcase
        return s;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run  = 1'b0;
            m_done = 1'b0;
            m_k    = 0;
        end else begin
            m_done = 1'b0;
            if (m_run) begin
                if (abort) m_run = 1'b0;
                else if (out_ready) begin
                    if (m_k == m_len - 1) begin
                        m_run  = 1'b0;
                        m_done = 1'b1;
                    end else m_k++;
                end
            end else if (start) begin
                if (burst_len != 16'd0) begin
                    m_run  = 1'b1;
                    m_k    = 0;
                    m_mode = int'(mode);
                    m_len  = int'(burst_len);
                end else m_done = 1'b1;
            end
        end
    end

    task automatic check_dut(input string nm, input int n, input int seed, input logic v,
                             input logic b, input logic dn, input logic l,
                             input logic [3:0] dat, input int ch);
        chk({nm, ".valid"}, int'(v), int'(m_run));
        chk({nm, ".busy"}, int'(b), int'(m_run));
        chk({nm, ".done"}, int'(dn), int'(m_done));
        if (m_run) begin
            chk({nm, ".data"}, int'(dat), exp_pat(n, seed, m_mode, m_k));
            chk({nm, ".chan"}, ch, m_k % n);
            chk({nm, ".last"}, int'(l), int'(m_k == m_len - 1));
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            check_dut("u4", 4, 0, v4, b4, d4, l4, dat4, int'(ch4));
            check_dut("u1", 1, 1, v1, b1, d1, l1, dat1, int'(ch1));
            check_dut("u2", 2, 9, v2, b2, d2, l2, dat2, int'(ch2));
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_ready) begin
            if (v4) q4.push_back(dat4);
            if (v1) q1.push_back(dat1);
            if (v2) q2.push_back(dat2);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_burst(input int m, input int len);
        start = 1'b1;
        mode = 2'(m);
        burst_len = 16'(len);
        step();
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (m_run && n < 300) begin
            step();
            n++;
        end
        if (n >= 300) begin
            failures++;
            $display("FAIL wait_idle timeout t=%0t", $time);
        end
    endtask

    task automatic cmp_q(input string nm, input logic [3:0] q[$], input int e[$]);
        chk({nm, ".count"}, q.size(), e.size());
        foreach (e[i]) if (i < q.size()) chk({nm, ".beat"}, int'(q[i]), e[i]);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, ".valid"}, int'(v4) + int'(v1) + int'(v2), 0);
        chk({nm, ".data"}, int'(dat4) + int'(dat1) + int'(dat2), 0);
        chk({nm, ".chan"}, int'(ch4) + int'(ch1) + int'(ch2), 0);
        chk({nm, ".last"}, int'(l4) + int'(l1) + int'(l2), 0);
        chk({nm, ".busy"}, int'(b4) + int'(b1) + int'(b2), 0);
        chk({nm, ".done"}, int'(d4) + int'(d1) + int'(d2), 0);
    endtask

    initial begin
        foreach (exp_inc[i])  chk("model.inc",  exp_pat(4, 0, 1, i), exp_inc[i]);
        foreach (exp_lfsr[i]) chk("model.lfsr", exp_pat(1, 1, 3, i), exp_lfsr[i]);
        foreach (exp_walk[i]) chk("model.walk", exp_pat(2, 9, 2, i), exp_walk[i]);

        repeat (3) @(negedge clk);
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        step();

        q4.delete();
        start_burst(1, 6);
        wait_idle();
        step();
        cmp_q("inc_burst", q4, exp_inc);

        q4.delete();
        start_burst(1, 6);
        step();
        step();
        out_ready = 1'b0;
        repeat (3) step();
        out_ready = 1'b1;
        wait_idle();
        step();
        cmp_q("stall_burst", q4, exp_inc);

        q1.delete();
        start_burst(3, 16);
        wait_idle();
        step();
        cmp_q("lfsr_burst", q1, exp_lfsr);

        q2.delete();
        start_burst(2, 8);
        wait_idle();
        step();
        cmp_q("walk_burst", q2, exp_walk);

        start_burst(1, 10);
        step();
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();

        start_burst(1, 10);
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        start_burst(1, 5);
        wait_idle();
        step();

        start_burst(1, 0);
        step();
        step();

        q4.delete();
        start_burst(1, 6);
        step();
        start_burst(3, 2);
        wait_idle();
        step();
        cmp_q("busy_start", q4, exp_inc);

        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 3) == 0);
            mode = 2'($urandom_range(0, 3));
            burst_len = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 12));
            out_ready = ($urandom_range(0, 4) != 0);
            abort = ($urandom_range(0, 40) == 0);
            step();
        end
        start = 1'b0;
        abort = 1'b0;
        out_ready = 1'b1;
        wait_idle();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pattern_src_mc.md
Name: pattern_src_mc

Overview:
Parametrised successor of the fixed-width 4-bit data-source submodule used in the automatic-wire fixtures. It produces a burst of test-pattern beats, interleaved round-robin over NUM_CHAN channels, on a valid/ready stream. Data width, channel count and pattern mode are generalised. Its registered outputs drive wires that automatic-wire generation must declare at multiple widths.

Parameters:
DATA_W, 4, data width in bits (≥2)
NUM_CHAN, 4, number of interleaved channels (≥1)
CHAN_W, max(1,$clog2(NUM_CHAN)), channel-id width (derived localparam, not overridable)
SEED, 0, pattern seed (DATA_W bits)
LFSR_POLY, 4'b1100, Galois tap mask for mode 3 (DATA_W bits)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin burst; sampled only in IDLE
abort  input  1  cancel burst in RUN
mode  input  2  0 constant, 1 increment, 2 walking-one, 3 LFSR; sampled at start
burst_len  input  16  total beats across all channels; sampled at start
out_valid  output  1  beat valid
out_ready  input  1  sink accepts
out_data  output  DATA_W  pattern value
out_chan  output  CHAN_W  channel of current beat
out_last  output  1  final beat of burst
busy  output  1  high in RUN
done  output  1  one-cycle pulse at normal burst completion

Behaviour:
- Reset (async assert, sync release): state IDLE; out_valid, out_data, out_chan, out_last, busy, done all 0; all per-channel pattern registers and beat counter 0.
- States: IDLE, RUN. All outputs registered.
- IDLE, start=1, burst_len>0: latch mode and burst_len; init per-channel state; chan ptr=0; beat count=0. Next cycle: RUN, busy=1, out_valid=1, first beat (chan 0) presented. Latency start→first valid = 1 cycle.
- IDLE, start=1, burst_len=0: stay IDLE, no beats; done=1 next cycle.
- Per-channel init for channel c (all arithmetic mod 2^DATA_W):
  - mode 0: SEED
  - mode 1: SEED+c
  - mode 2: 1<<(c mod DATA_W)
  - mode 3: SEED^c; forced to 1 if result is 0
- Accept = out_valid & out_ready. On accept:
  - Advance that channel's state: mode 0 unchanged; mode 1 +1 with wrap; mode 2 rotate left 1; mode 3 s=(s>>1)^(s[0]?LFSR_POLY:0).
  - chan ptr increments, wrapping NUM_CHAN-1→0.
  - beat count increments.
  - Next beat is presented the following cycle, so full throughput is 1 beat/cycle with out_ready held high.
- out_data always equals the current state of channel out_chan.
- out_last=1 exactly when beat count = burst_len-1.
- Accept with out_last=1: next cycle IDLE; out_valid=0, busy=0, out_last=0; done=1 for one cycle.
- Stall (out_valid=1, out_ready=0): out_data, out_chan and out_last held stable; out_valid never drops without an accept or abort.
- abort=1 in RUN: next cycle IDLE; out_valid=0, busy=0; no done pulse. If abort and accept occur in the same cycle, abort wins; that beat counts as delivered but no done pulse is generated.
- start while busy: ignored. abort in IDLE: ignored.
- start in the done-pulse cycle is legal and begins a new burst.
- Reset mid-burst: immediate return to reset values; no done pulse.
- NUM_CHAN=1: out_chan constant 0; all beats come from channel 0.

Test Plan:
- DATA_W=4, NUM_CHAN=4, SEED=0, mode 1, burst_len=6, ready=1 → data 0,1,2,3,1,2; chan 0,1,2,3,0,1; out_last on beat 6 only; done one cycle after; first valid one cycle after start.
- Same burst with out_ready low for 3 cycles at beat 3 → data=2, chan=2 held 3 cycles; full sequence unchanged; no duplicated or lost beats.
- NUM_CHAN=1, SEED=1, mode 3, burst_len=16 → 1,C,6,3,D,A,5,E,7,F,B,9,8,4,2,1 (hex).
- NUM_CHAN=2, mode 2, burst_len=8 → 1,2,2,4,4,8,8,1.
- abort at beat 3 → out_valid=0 next cycle, no done; then rst_n low mid-burst → all outputs 0 immediately; new start restarts at chan 0 with init values.
- burst_len=0 start → no out_valid; done=1 next cycle. start while busy → ignored; sequence unaffected.
